// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator operand-entry path
package calc_pkg;
  typedef enum logic {RADIX_HEX = 1'b0, RADIX_DEC = 1'b1} radix_e;
  localparam int KEY_DIGIT_MAX_DEC = 9;
  localparam int KEY_NONDIGIT_BIT = 4;
  localparam int FULL_SHIFT = 0;
  localparam int FULL_REJECT = 1;
endpackage

// File: rtl/key_classifier.sv
// key_classifier: decides whether a key code is a digit legal in the current radix
module key_classifier
  import calc_pkg::*;
#(
  parameter int KEY_W = 5,
  parameter int DIGIT_W = 4
) (
  input  logic [KEY_W-1:0]   key_in,
  input  logic               radix,
  output logic               is_digit,
  output logic [DIGIT_W-1:0] digit
);
  assign digit = key_in[DIGIT_W-1:0];
  assign is_digit = !key_in[KEY_W-1] &&
                    (radix_e'(radix) == RADIX_HEX || digit <= DIGIT_W'(KEY_DIGIT_MAX_DEC));
endmodule

// File: rtl/digit_entry_reg.sv
// digit_entry_reg: keypad operand entry with radix check, backspace, zero suppression and full policy
module digit_entry_reg
  import calc_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter int KEY_W = KEY_NONDIGIT_BIT + 1,
  parameter int FULL_MODE = FULL_SHIFT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           radix,
  input  logic [KEY_W-1:0]               key_in,
  output logic [NDIGITS*DIGIT_W-1:0]     dato,
  output logic [$clog2(NDIGITS+1)-1:0]   count,
  output logic                           empty,
  output logic                           full,
  output logic                           err,
  output logic                           ovf
);
  localparam int DW = NDIGITS * DIGIT_W;
  localparam int CW = $clog2(NDIGITS + 1);
  logic [DW-1:0] dato_q, dato_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d, err_q, err_d;
  logic is_digit;
  logic [DIGIT_W-1:0] digit;
  logic is_empty, is_full;
  logic [DW-1:0] shifted_in;
  key_classifier #(.KEY_W(KEY_W), .DIGIT_W(DIGIT_W)) u_cls (
    .key_in  (key_in),
    .radix   (radix),
    .is_digit(is_digit),
    .digit   (digit)
  );
  assign is_empty = count_q == '0;
  assign is_full = count_q == CW'(NDIGITS);
  assign shifted_in = {dato_q[DW-DIGIT_W-1:0], digit};
  always_ff @(posedge clk) begin
    if (rst) begin
      dato_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      dato_q <= dato_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    dato_d = dato_q;
    count_d = count_q;
    ovf_d = ovf_q;
    err_d = 1'b0;
    if (clear) begin
      dato_d = '0;
      count_d = '0;
      ovf_d = 1'b0;
    end else if (push && pop) begin
      err_d = 1'b1;
    end else if (push) begin
      if (!is_digit) begin
        err_d = 1'b1;
      end else if (is_empty && digit == '0) begin
        // leading zero: operand stays blank
      end else if (!is_full) begin
        dato_d = shifted_in;
        count_d = count_q + CW'(1);
      end else if (FULL_MODE == FULL_SHIFT) begin
        dato_d = shifted_in;
        ovf_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (pop) begin
      err_d = is_empty;
      dato_d = is_empty ? dato_q : {DIGIT_W'(0), dato_q[DW-1:DIGIT_W]};
      count_d = is_empty ? count_q : count_q - CW'(1);
    end
  end
  always_comb begin
    dato = dato_q;
    count = count_q;
    empty = is_empty;
    full = is_full;
    err = err_q;
    ovf = ovf_q;
  end
endmodule

// File: tb/tb_digit_entry_reg.sv
// tb_digit_entry_reg: checks both full policies against a digit-list reference model
module tb_digit_entry_reg;
  logic clk = 1'b0;
  logic rst, clear, push, pop, radix;
  logic [4:0] key_in;
  logic [15:0] dato [2];
  logic [2:0] count [2];
  logic empty [2];
  logic full [2];
  logic err [2];
  logic ovf [2];
  int checks = 0;
  int errors = 0;
  int mq [2][$];
  bit m_ovf [2];
  bit m_err [2];

  always #5 clk = ~clk;

  digit_entry_reg #(.FULL_MODE(0)) dut_shift (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop), .radix(radix), .key_in(key_in),
    .dato(dato[0]), .count(count[0]), .empty(empty[0]), .full(full[0]), .err(err[0]), .ovf(ovf[0])
  );
  digit_entry_reg #(.FULL_MODE(1)) dut_reject (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop), .radix(radix), .key_in(key_in),
    .dato(dato[1]), .count(count[1]), .empty(empty[1]), .full(full[1]), .err(err[1]), .ovf(ovf[1])
  );

  function automatic int model_value(int m);
    int v = 0;
    foreach (mq[m][i]) v = v * 16 + mq[m][i];
    return v;
  endfunction

  task automatic model_update(int m, bit r, bit c, bit pu, bit po, bit rd, logic [4:0] k);
    int d = int'(k[3:0]);
    bit ok = !k[4] && (!rd || d <= 9);
    m_err[m] = 0;
    if (r || c) begin
      mq[m].delete();
      m_ovf[m] = 0;
    end else if (pu && po) m_err[m] = 1;
    else if (pu) begin
      if (!ok) m_err[m] = 1;
      else if (mq[m].size() == 0 && d == 0) ;
      else if (mq[m].size() < 4) mq[m].push_back(d);
      else if (m == 0) begin
        void'(mq[m].pop_front());
        mq[m].push_back(d);
        m_ovf[m] = 1;
      end else m_err[m] = 1;
    end else if (po) begin
      if (mq[m].size() == 0) m_err[m] = 1;
      else void'(mq[m].pop_back());
    end
  endtask

  task automatic step(bit r, bit c, bit pu, bit po, bit rd, logic [4:0] k);
    rst = r; clear = c; push = pu; pop = po; radix = rd; key_in = k;
    @(posedge clk);
    #1;
    rst = 0; clear = 0; push = 0; pop = 0;
    for (int m = 0; m < 2; m++) model_update(m, r, c, pu, po, rd, k);
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0, 5'h00);
    for (int m = 0; m < 2; m++) begin
      checks++; if (dato[m] !== 16'h0) begin errors++; $display("FAIL reset_dato[%0d] got %h want 0000", m, dato[m]); end
      checks++; if (count[m] !== 3'd0) begin errors++; $display("FAIL reset_count[%0d] got %0d want 0", m, count[m]); end
      checks++; if ({empty[m], full[m], err[m], ovf[m]} !== 4'b1000) begin errors++; $display("FAIL reset_flags[%0d] got %b want 1000", m, {empty[m], full[m], err[m], ovf[m]}); end
    end
  endtask

  task automatic test_fill;
    logic [4:0] keys [4] = '{5'h01, 5'h02, 5'h0A, 5'h0F};
    foreach (keys[i]) begin
      step(0, 0, 1, 0, 0, keys[i]);
      for (int m = 0; m < 2; m++) begin
        checks++; if (err[m] !== 1'b0) begin errors++; $display("FAIL fill_err[%0d] key %h got %b want 0", m, keys[i], err[m]); end
      end
    end
    for (int m = 0; m < 2; m++) begin
      checks++; if (dato[m] !== 16'h12AF) begin errors++; $display("FAIL fill_dato[%0d] got %h want 12af", m, dato[m]); end
      checks++; if (count[m] !== 3'd4 || full[m] !== 1'b1 || empty[m] !== 1'b0) begin errors++; $display("FAIL fill_count[%0d] got %0d/%b want 4/full", m, count[m], full[m]); end
    end
  endtask

  task automatic test_full_policy;
    step(0, 0, 1, 0, 0, 5'h03);
    checks++; if (dato[0] !== 16'h2AF3 || count[0] !== 3'd4) begin errors++; $display("FAIL shift_dato got %h/%0d want 2af3/4", dato[0], count[0]); end
    checks++; if (ovf[0] !== 1'b1 || err[0] !== 1'b0) begin errors++; $display("FAIL shift_ovf got ovf %b err %b want 1 0", ovf[0], err[0]); end
    checks++; if (dato[1] !== 16'h12AF || err[1] !== 1'b1 || ovf[1] !== 1'b0) begin errors++; $display("FAIL reject got %h err %b ovf %b want 12af 1 0", dato[1], err[1], ovf[1]); end
    step(0, 0, 0, 0, 0, 5'h00);
    checks++; if (err[1] !== 1'b0 || ovf[0] !== 1'b1) begin errors++; $display("FAIL err_pulse got err %b ovf %b want 0 1", err[1], ovf[0]); end
    step(0, 1, 0, 0, 0, 5'h00);
    for (int m = 0; m < 2; m++) begin
      checks++; if (dato[m] !== 16'h0 || count[m] !== 3'd0 || ovf[m] !== 1'b0 || empty[m] !== 1'b1) begin errors++; $display("FAIL clear[%0d] got %h/%0d ovf %b empty %b want 0/0 0 1", m, dato[m], count[m], ovf[m], empty[m]); end
    end
  endtask

  task automatic test_radix_dec;
    step(0, 0, 1, 0, 1, 5'h00);
    checks++; if (dato[0] !== 16'h0 || count[0] !== 3'd0 || err[0] !== 1'b0) begin errors++; $display("FAIL lead_zero got %h/%0d err %b want 0/0 0", dato[0], count[0], err[0]); end
    step(0, 0, 1, 0, 1, 5'h0B);
    checks++; if (err[0] !== 1'b1 || dato[0] !== 16'h0) begin errors++; $display("FAIL dec_B got err %b dato %h want 1 0000", err[0], dato[0]); end
    step(0, 0, 1, 0, 1, 5'h10);
    checks++; if (err[1] !== 1'b1 || count[1] !== 3'd0) begin errors++; $display("FAIL nondigit got err %b count %0d want 1 0", err[1], count[1]); end
    step(0, 0, 1, 0, 1, 5'h07);
    checks++; if (dato[0] !== 16'h0007 || count[0] !== 3'd1 || err[0] !== 1'b0) begin errors++; $display("FAIL dec_7 got %h/%0d err %b want 0007/1 0", dato[0], count[0], err[0]); end
  endtask

  task automatic test_backspace;
    step(0, 1, 0, 0, 0, 5'h00);
    step(0, 0, 1, 0, 0, 5'h01);
    step(0, 0, 1, 0, 0, 5'h02);
    step(0, 0, 1, 0, 0, 5'h03);
    checks++; if (dato[0] !== 16'h0123 || count[0] !== 3'd3) begin errors++; $display("FAIL bs_setup got %h/%0d want 0123/3", dato[0], count[0]); end
    step(0, 0, 0, 1, 0, 5'h00);
    checks++; if (dato[0] !== 16'h0012 || count[0] !== 3'd2 || err[0] !== 1'b0) begin errors++; $display("FAIL bs_pop1 got %h/%0d want 0012/2", dato[0], count[0]); end
    step(0, 0, 0, 1, 0, 5'h00);
    step(0, 0, 0, 1, 0, 5'h00);
    checks++; if (dato[1] !== 16'h0 || empty[1] !== 1'b1 || count[1] !== 3'd0) begin errors++; $display("FAIL bs_empty got %h empty %b want 0000 1", dato[1], empty[1]); end
    step(0, 0, 0, 1, 0, 5'h00);
    checks++; if (err[0] !== 1'b1 || dato[0] !== 16'h0 || empty[0] !== 1'b1) begin errors++; $display("FAIL bs_underflow got err %b dato %h want 1 0000", err[0], dato[0]); end
  endtask

  task automatic test_back_to_back;
    step(0, 0, 1, 0, 0, 5'h04);
    step(0, 0, 1, 0, 0, 5'h05);
    step(0, 0, 1, 1, 0, 5'h06);
    checks++; if (dato[0] !== 16'h0045 || count[0] !== 3'd2 || err[0] !== 1'b1) begin errors++; $display("FAIL push_pop got %h/%0d err %b want 0045/2 1", dato[0], count[0], err[0]); end
    step(1, 0, 1, 0, 0, 5'h07);
    for (int m = 0; m < 2; m++) begin
      checks++; if (dato[m] !== 16'h0 || count[m] !== 3'd0 || err[m] !== 1'b0) begin errors++; $display("FAIL rst_push[%0d] got %h/%0d err %b want 0/0 0", m, dato[m], count[m], err[m]); end
    end
  endtask

  task automatic test_random;
    bit r, c, pu, po, rd;
    logic [4:0] k;
    int sel;
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 99);
      r = sel == 0;
      c = sel == 1;
      pu = sel >= 2 && sel < 60 || sel >= 95;
      po = sel >= 60 && sel < 90 || sel >= 95;
      rd = $urandom_range(0, 1);
      k = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      step(r, c, pu, po, rd, k);
      for (int m = 0; m < 2; m++) begin
        checks++; if (int'(dato[m]) !== model_value(m)) begin errors++; $display("FAIL rnd_dato[%0d] step %0d got %h want %h", m, n, dato[m], model_value(m)); end
        checks++; if (int'(count[m]) !== mq[m].size()) begin errors++; $display("FAIL rnd_count[%0d] step %0d got %0d want %0d", m, n, count[m], mq[m].size()); end
        checks++; if (empty[m] !== (mq[m].size() == 0) || full[m] !== (mq[m].size() == 4)) begin errors++; $display("FAIL rnd_flags[%0d] step %0d got e%b f%b want size %0d", m, n, empty[m], full[m], mq[m].size()); end
        checks++; if (err[m] !== m_err[m] || ovf[m] !== m_ovf[m]) begin errors++; $display("FAIL rnd_err_ovf[%0d] step %0d got %b%b want %b%b", m, n, err[m], ovf[m], m_err[m], m_ovf[m]); end
      end
    end
  endtask

  initial begin
    rst = 0; clear = 0; push = 0; pop = 0; radix = 0; key_in = '0;
    test_reset;
    test_fill;
    test_full_policy;
    test_radix_dec;
    test_backspace;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/digit_entry_reg.md
Name: digit_entry_reg

Overview:
Parametrised operand-entry register for the calculator datapath.
- Accepts one key code per push pulse and shifts it in as the new least-significant digit of the displayed operand.
- Adds over the single-width shift register:
  - radix-checked digit validation (hex/decimal);
  - backspace;
  - leading-zero suppression;
  - digit count with full/empty flags;
  - selectable full policy.
- Sits between the debounced/edge-detected keypad logic and the calculator ALU/display mux.

Parameters:
NDIGITS, 4, number of digits held (≥2).
DIGIT_W, 4, bits per digit.
KEY_W, 5, width of key code (bit KEY_W-1 set = non-digit key).
FULL_MODE, 0, 0 = shift out oldest digit when full; 1 = reject digit when full.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clear  in  1  synchronous clear from calculator control (same effect as rst)
push  in  1  one-cycle pulse: enter key_in
pop  in  1  one-cycle pulse: backspace (delete least-significant digit)
radix  in  1  0 = hex (0..F valid), 1 = decimal (0..9 valid)
key_in  in  KEY_W  key code; digit value in [DIGIT_W-1:0]
dato  out  NDIGITS*DIGIT_W  entered operand, digit 0 at LSBs
count  out  $clog2(NDIGITS+1)  number of significant digits entered
empty  out  1  count == 0
full  out  1  count == NDIGITS
err  out  1  one-cycle pulse on rejected operation
ovf  out  1  sticky: a digit was shifted out (FULL_MODE=0); cleared by rst/clear

Behaviour:
- All state updates on posedge clk. dato/count/flags reflect an operation one cycle after the pulse. err is registered and asserts in that same cycle, for exactly one cycle.
- Reset/clear values: dato=0, count=0, empty=1, full=0, err=0, ovf=0.
- Priority: rst > clear > (push & pop) > push > pop > hold. rst or clear mid-entry discards all digits. err is not raised by rst/clear.
- push & pop in the same cycle: no state change, err=1.
- Valid push requires:
  - key_in[KEY_W-1]=0;
  - and, when radix=1, key_in[DIGIT_W-1:0] ≤ 9.
  - Invalid key: no change, err=1.
- Valid push, empty, digit 0 (leading-zero suppression): dato stays 0, count stays 0, no err.
- Valid push, not full: dato <= {dato[(NDIGITS-1)*DIGIT_W-1:0], d}, count+1.
- Valid push when full:
  - FULL_MODE=0: shift as above (oldest digit lost), count stays NDIGITS, ovf<=1.
  - FULL_MODE=1: no change, err=1.
- pop, not empty: dato <= {DIGIT_W'0, dato[NDIGITS*DIGIT_W-1:DIGIT_W]}, count-1.
- pop when empty: no change, err=1.
- radix changes do not alter stored digits; validation uses radix at push time.
- push/pop are level-sampled each cycle. The upstream edge detector guarantees single-cycle pulses; the block does no edge detection.

Decomposition:
- Shared package calc_pkg:
  - radix enum (RADIX_HEX, RADIX_DEC);
  - key-code constants (KEY_DIGIT_MAX_DEC=9, non-digit flag bit position);
  - full-policy constants (FULL_SHIFT=0, FULL_REJECT=1).
- One combinational sub-module, key_classifier:
  - in: key_in, radix;
  - out: is_digit, digit value.
- The shift/count FSM stays in digit_entry_reg.

Test Plan:
1. Defaults, radix=0: rst, then push 0x01,0x02,0x0A,0x0F -> dato=0x12AF, count=4, full=1, err never set.
2. FULL_MODE=0, from state 0x12AF: push 0x03 -> dato=0x2AF3, count=4, ovf=1. Then clear -> dato=0, count=0, ovf=0, empty=1.
3. FULL_MODE=1, state 0x12AF: push 0x05 -> dato unchanged, err pulses 1 cycle.
4. radix=1, empty: push 0x00 -> dato=0, count=0, no err. Push 0x0B -> err=1, no change. Push 0x10 (non-digit) -> err=1. Push 0x07 -> dato=0x0007, count=1.
5. State 0x0123, count=3: pop -> dato=0x0012, count=2. pop, pop -> dato=0, empty=1. Further pop -> err=1, no change.
6. push & pop in the same cycle with count=2 -> no change, err=1. rst asserted in the same cycle as a push -> dato=0, count=0, err=0.
